soc_coulomb_estimator: RTL and testbench
========================================

// Module: soc_coulomb_estimator
// PURPOSE
// - Coulomb-counting state-of-charge estimator; produces soc_percent consumed by the SoC protection stage.
// - Integrates signed pack-current samples into a residual charge accumulator.
// - Moves soc_percent by whole-percent steps through an iterative normalise FSM, so no divider is needed.
// - Seeded from an external OCV-based initial SoC.
// PARAMETERS
// - CAP_MAS   32'd3_600_000  pack capacity in mA*s (1 Ah); must be >= 100
// - CUR_W     16             width of signed current sample (mA; positive = charging)
// - EFF_Q8    8'd250         charge efficiency, Q0.8 (250/256); used only with SOC_COULOMB_EFF_EN
// - localparam STEP = CAP_MAS/100 (floor); charge in mA*s equal to one percent
// PORTS
// - clk            in   1      system clock
// - rst            in   1      synchronous, active-high reset
// - init_valid     in   1      load init_soc (single-cycle strobe)
// - init_soc       in   8      initial SoC in percent; values > 100 clamp to 100
// - sample_valid   in   1      current sample present; one sample = 1 s of charge flow
// - sample_ready   out  1      estimator accepts a sample this cycle
// - current_ma     in   CUR_W  signed current in mA
// - soc_percent    out  8      SoC 0..100, to soc protection
// - soc_valid      out  1      soc_percent is meaningful (after first init)
// - soc_update     out  1      1-cycle pulse when soc_percent changes
// BEHAVIOUR
// - Clock is one clock (clk); reset is synchronous and active-high (rst).
// - Reset values:
//   - soc_percent=0, soc_valid=0, sample_ready=0, soc_update=0
//   - residual=0, state=UNINIT
// - Residual is signed, 33 bits plus CUR_W headroom; it holds the sub-percent charge.
// - Invariant between updates: 0 <= residual < STEP.
// - UNINIT: sample_ready=0; samples are ignored. On init_valid -> RUN.
// - Init (from any state, including NORM):
//   - On the next edge: soc_percent=min(init_soc,100), residual=0, soc_valid=1, state=RUN.
//   - soc_update=1 only if the value changed.
//   - Init wins over a same-cycle sample; that sample is dropped.
// - RUN: sample_ready=1. On sample_valid&&sample_ready, the next edge does residual += current_ma.
//   - Result in [0,STEP): stay in RUN; no update pulse.
//   - Otherwise: state=NORM.
// - NORM: sample_ready=0. Exactly one adjustment per cycle:
//   - residual >= STEP: soc+1, residual-=STEP.
//   - residual < 0: soc-1, residual+=STEP.
//   - When back in range: return to RUN, pulse soc_update for 1 cycle if soc_percent differs from its value on NORM entry.
//   - Latency is 1 + |percent steps| cycles from acceptance to the pulse.
// - Saturation:
//   - At soc=100 with residual >= STEP: residual clamps to 0 and the FSM exits.
//   - At soc=0 with residual < 0: residual clamps to 0 and the FSM exits.
//   - soc_percent never leaves 0..100.
// - rst mid-NORM: abandons normalisation and returns to reset values (soc_valid=0).
// CONFIGURATION
// - SOC_COULOMB_EFF_EN defined: positive current_ma is scaled by (current_ma*EFF_Q8)>>>8 before accumulation.
//   - This adds one register stage: acceptance -> accumulate takes 2 cycles.
//   - sample_ready stays 0 during that stage.
//   - Negative current is unscaled.
// - SOC_COULOMB_EFF_EN undefined: raw current is accumulated in 1 cycle; EFF_Q8 is unused.
// STRUCTURE
// - Shared package bms_pkg:
//   - SOC_MAX=8'd100, SOC_W=8
//   - state enum {UNINIT,RUN,NORM}
//   - current sign convention
//   - also used by soc_protection limits
// - One sub-module: soc_charge_eff_scaler, the optional efficiency multiply/shift stage under the macro.
// - Remaining logic (FSM, residual, clamp) stays in this module.
// TESTING
// - Tests use CAP_MAS=10000 (STEP=100) and the macro undefined unless stated.
// - rst, sample_valid=1 cur=+500 with no init -> sample_ready=0; soc_valid=0, soc_percent=0 hold.
// - init 50, sample +250 -> NORM 2 cycles, soc 52, residual 50, soc_update 1 pulse, ready low 2 cycles.
// - init 1, sample -350 -> soc 0, residual clamps to 0, single update pulse; next sample -10 -> soc stays 0, no pulse.
// - init 150 -> soc 100; sample +1000 -> soc 100, residual 0, no update pulse.
// - init 40, sample +400, init_valid=30 during 2nd NORM cycle -> soc 30 next edge, residual 0, state RUN.
// - SOC_COULOMB_EFF_EN, init 10, sample +512 -> scaled 500 -> soc 15, residual 0.

Source files
------------

// File: rtl/bms_pkg.sv
// Shared BMS definitions: SoC range, estimator FSM states and current sign convention.
// Pack current is signed mA, positive while charging; soc_protection limits use the same SoC range.
package bms_pkg;

  localparam int         SOC_W   = 8;
  localparam logic [7:0] SOC_MAX = 8'd100;

  typedef enum logic [1:0] {
    ST_UNINIT = 2'd0,
    ST_RUN    = 2'd1,
    ST_NORM   = 2'd2
  } soc_state_e;

  function automatic logic [SOC_W-1:0] clamp_soc(input logic [SOC_W-1:0] v);
    return (v > SOC_MAX) ? SOC_MAX : v;
  endfunction

endpackage

// File: rtl/soc_charge_eff_scaler.sv
// Registered charge-efficiency stage: positive current scaled by EFF_Q8/256, negative passed through.
// Instantiated only when SOC_COULOMB_EFF_EN is defined.
module soc_charge_eff_scaler #(
  parameter int         CUR_W  = 16,
  parameter logic [7:0] EFF_Q8 = 8'd250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic signed [CUR_W-1:0] in_ma,
  output logic                    out_valid,
  output logic signed [CUR_W-1:0] out_ma
);

  logic signed [CUR_W+8:0] prod;
  logic                    out_valid_d, out_valid_q;
  logic signed [CUR_W-1:0] out_ma_d, out_ma_q;

  always_comb begin
    prod        = $signed({{9{in_ma[CUR_W-1]}}, in_ma}) * $signed({{(CUR_W + 1){1'b0}}, EFF_Q8});
    out_ma_d    = in_ma;
    if (!in_ma[CUR_W-1]) begin
      // Gain is below 1, so the shifted product always fits back in CUR_W bits.
      out_ma_d = CUR_W'(prod >>> 8);
    end
    out_valid_d = in_valid && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ma_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ma_q    <= out_ma_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ma    = out_ma_q;

endmodule

// File: rtl/soc_coulomb_estimator.sv
// Coulomb-counting SoC estimator: integrates current into a residual and walks soc_percent one step per cycle.
// Optional macro SOC_COULOMB_EFF_EN inserts the registered charge-efficiency stage.
module soc_coulomb_estimator
  import bms_pkg::*;
#(
  parameter logic [31:0] CAP_MAS = 32'd3_600_000,
  parameter int          CUR_W   = 16,
  parameter logic [7:0]  EFF_Q8  = 8'd250,
  localparam int         RES_W   = 33 + CUR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_valid,
  input  logic [7:0]              init_soc,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic signed [CUR_W-1:0] current_ma,
  output logic [7:0]              soc_percent,
  output logic                    soc_valid,
  output logic                    soc_update,
  output logic [1:0]              dbg_state,
  output logic signed [RES_W-1:0] dbg_residual
);

  localparam logic signed [RES_W-1:0] STEP = $signed({{(RES_W - 32){1'b0}}, CAP_MAS / 32'd100});

  soc_state_e              state_q, state_d;
  logic [SOC_W-1:0]        soc_q, soc_d;
  logic [SOC_W-1:0]        entry_q, entry_d;
  logic signed [RES_W-1:0] res_q, res_d;
  logic                    valid_q, valid_d;
  logic                    upd_q, upd_d;

  logic                    acc_en;
  logic signed [CUR_W-1:0] acc_ma;
  logic signed [RES_W-1:0] acc_ext, res_sum, res_adj;
  logic [SOC_W-1:0]        soc_adj;

  // Handshake: a sample transfers on a cycle where sample_valid && sample_ready; ready depends only on
  // registered state, and a same-cycle init_valid discards the transferred sample.
`ifdef SOC_COULOMB_EFF_EN
  logic                    stage_valid;
  logic signed [CUR_W-1:0] stage_ma;
  logic                    stage_in_valid;

  always_comb begin
    sample_ready   = (state_q == ST_RUN) && !stage_valid;
    stage_in_valid = sample_valid && sample_ready && !init_valid;
    acc_en         = stage_valid;
    acc_ma         = stage_ma;
  end

  soc_charge_eff_scaler #(
    .CUR_W (CUR_W),
    .EFF_Q8(EFF_Q8)
  ) u_eff_scaler (
    .clk      (clk),
    .rst      (rst),
    .flush    (init_valid),
    .in_valid (stage_in_valid),
    .in_ma    (current_ma),
    .out_valid(stage_valid),
    .out_ma   (stage_ma)
  );
`else
  always_comb begin
    sample_ready = (state_q == ST_RUN);
    acc_en       = sample_valid && sample_ready;
    acc_ma       = current_ma;
  end
`endif

  always_comb begin
    state_d = state_q;
    soc_d   = soc_q;
    entry_d = entry_q;
    res_d   = res_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    acc_ext = {{(RES_W - CUR_W){acc_ma[CUR_W-1]}}, acc_ma};
    res_sum = res_q + acc_ext;
    res_adj = res_q;
    soc_adj = soc_q;

    if (init_valid) begin
      soc_d   = clamp_soc(init_soc);
      res_d   = '0;
      valid_d = 1'b1;
      state_d = ST_RUN;
      upd_d   = (clamp_soc(init_soc) != soc_q);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (acc_en) begin
            res_d = res_sum;
            if (res_sum[RES_W-1] || (res_sum >= STEP)) begin
              state_d = ST_NORM;
              entry_d = soc_q;
            end
          end
        end
        ST_NORM: begin
          // One whole-percent move per cycle; at either end of the range the residual is discarded.
          if (res_q >= STEP) begin
            if (soc_q == SOC_MAX) begin
              res_adj = '0;
            end else begin
              soc_adj = soc_q + 1'b1;
              res_adj = res_q - STEP;
            end
          end else if (res_q[RES_W-1]) begin
            if (soc_q == '0) begin
              res_adj = '0;
            end else begin
              soc_adj = soc_q - 1'b1;
              res_adj = res_q + STEP;
            end
          end
          soc_d = soc_adj;
          res_d = res_adj;
          if (!res_adj[RES_W-1] && (res_adj < STEP)) begin
            state_d = ST_RUN;
            upd_d   = (soc_adj != entry_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNINIT;
      soc_q   <= '0;
      entry_q <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      entry_q <= entry_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
    end
  end

  assign soc_percent  = soc_q;
  assign soc_valid    = valid_q;
  assign soc_update   = upd_q;
  assign dbg_state    = state_q;
  assign dbg_residual = res_q;

endmodule

// File: tb/tb_soc_coulomb_estimator.sv
// Directed bench for soc_coulomb_estimator with CAP_MAS=10000 (one percent = 100 mA*s).
// Snapshot order: {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual}.
module tb_soc_coulomb_estimator;
  import bms_pkg::*;

  localparam int CUR_W  = 16;
  localparam int RES_W  = 33 + CUR_W;
  localparam int SNAP_W = 8 + 1 + 1 + 1 + 2 + RES_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    init_valid = 1'b0;
  logic [7:0]              init_soc = '0;
  logic                    sample_valid = 1'b0;
  logic                    sample_ready;
  logic signed [CUR_W-1:0] current_ma = '0;
  logic [7:0]              soc_percent;
  logic                    soc_valid;
  logic                    soc_update;
  logic [1:0]              dbg_state;
  logic signed [RES_W-1:0] dbg_residual;

  int checks = 0;
  int errors = 0;
  logic [SNAP_W-1:0] snap;

  soc_coulomb_estimator #(
    .CAP_MAS(32'd10000),
    .CUR_W  (CUR_W),
    .EFF_Q8 (8'd250)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init_valid  (init_valid),
    .init_soc    (init_soc),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .current_ma  (current_ma),
    .soc_percent (soc_percent),
    .soc_valid   (soc_valid),
    .soc_update  (soc_update),
    .dbg_state   (dbg_state),
    .dbg_residual(dbg_residual)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input int v);
    init_valid = 1'b1;
    init_soc   = 8'(v);
    step();
    init_valid = 1'b0;
  endtask

  task automatic do_sample(input int cur);
    sample_valid = 1'b1;
    current_ma   = CUR_W'(cur);
    step();
    sample_valid = 1'b0;
  endtask

  function automatic logic [SNAP_W-1:0] mk(input int soc, input bit v, input bit r, input bit u,
                                           input int st, input longint res);
    logic [7:0]       s8;
    logic [1:0]       st2;
    logic [RES_W-1:0] r49;
    s8  = 8'(soc);
    st2 = 2'(st);
    r49 = RES_W'(res);
    return {s8, v, r, u, st2, r49};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [SNAP_W-1:0] e;
    rst = 1'b1;
    step();
    step();
    e = mk(0, 0, 0, 0, int'(ST_UNINIT), 0);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL reset got %h exp %h", snap, e); end
    rst = 1'b0;
    sample_valid = 1'b1;
    current_ma   = 16'sd500;
    for (int i = 0; i < 3; i++) begin
      step();
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== e) begin errors++; $display("FAIL uninit_ignore[%0d] got %h exp %h", i, snap, e); end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_norm_up();
    logic [SNAP_W-1:0] e [4];
    do_init(50);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== mk(50, 1, 1, 1, int'(ST_RUN), 0)) begin
      errors++; $display("FAIL init50 got %h exp %h", snap, mk(50, 1, 1, 1, int'(ST_RUN), 0));
    end
    e = '{mk(50, 1, 0, 0, int'(ST_NORM), 250), mk(51, 1, 0, 0, int'(ST_NORM), 150),
          mk(52, 1, 1, 1, int'(ST_RUN), 50),   mk(52, 1, 1, 0, int'(ST_RUN), 50)};
    do_sample(250);
    for (int i = 0; i < 4; i++) begin
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL norm_up[%0d] got %h exp %h", i, snap, e[i]); end
      step();
    end
  endtask

  task automatic test_floor_clamp();
    logic [SNAP_W-1:0] e [4];
    logic [SNAP_W-1:0] f [2];
    do_init(1);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== mk(1, 1, 1, 1, int'(ST_RUN), 0)) begin
      errors++; $display("FAIL init1 got %h exp %h", snap, mk(1, 1, 1, 1, int'(ST_RUN), 0));
    end
    e = '{mk(1, 1, 0, 0, int'(ST_NORM), -350), mk(0, 1, 0, 0, int'(ST_NORM), -250),
          mk(0, 1, 1, 1, int'(ST_RUN), 0),     mk(0, 1, 1, 0, int'(ST_RUN), 0)};
    do_sample(-350);
    for (int i = 0; i < 4; i++) begin
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL floor[%0d] got %h exp %h", i, snap, e[i]); end
      step();
    end
    f = '{mk(0, 1, 0, 0, int'(ST_NORM), -10), mk(0, 1, 1, 0, int'(ST_RUN), 0)};
    do_sample(-10);
    for (int i = 0; i < 2; i++) begin
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== f[i]) begin errors++; $display("FAIL floor_again[%0d] got %h exp %h", i, snap, f[i]); end
      step();
    end
  endtask

  task automatic test_ceiling_clamp();
    logic [SNAP_W-1:0] e [2];
    do_init(150);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== mk(100, 1, 1, 1, int'(ST_RUN), 0)) begin
      errors++; $display("FAIL init150 got %h exp %h", snap, mk(100, 1, 1, 1, int'(ST_RUN), 0));
    end
    e = '{mk(100, 1, 0, 0, int'(ST_NORM), 1000), mk(100, 1, 1, 0, int'(ST_RUN), 0)};
    do_sample(1000);
    for (int i = 0; i < 2; i++) begin
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL ceiling[%0d] got %h exp %h", i, snap, e[i]); end
      step();
    end
  endtask

  task automatic test_init_preempt();
    logic [SNAP_W-1:0] e;
    do_init(40);
    do_sample(400);
    e = mk(40, 1, 0, 0, int'(ST_NORM), 400);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL preempt_n1 got %h exp %h", snap, e); end
    step();
    e = mk(41, 1, 0, 0, int'(ST_NORM), 300);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL preempt_n2 got %h exp %h", snap, e); end
    do_init(30);
    e = mk(30, 1, 1, 1, int'(ST_RUN), 0);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL preempt_init got %h exp %h", snap, e); end
    // Init and sample together: the sample is dropped and the unchanged SoC gives no pulse.
    sample_valid = 1'b1;
    current_ma   = 16'sd500;
    do_init(30);
    sample_valid = 1'b0;
    e = mk(30, 1, 1, 0, int'(ST_RUN), 0);
    for (int i = 0; i < 2; i++) begin
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== e) begin errors++; $display("FAIL init_wins[%0d] got %h exp %h", i, snap, e); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [SNAP_W-1:0] e [3];
    logic [SNAP_W-1:0] g [4];
    sample_valid = 1'b1;
    current_ma   = 16'sd60;
    step();
    e[0] = mk(30, 1, 1, 0, int'(ST_RUN), 60);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e[0]) begin errors++; $display("FAIL b2b[0] got %h exp %h", snap, e[0]); end
    step();
    sample_valid = 1'b0;
    e[1] = mk(30, 1, 0, 0, int'(ST_NORM), 120);
    e[2] = mk(31, 1, 1, 1, int'(ST_RUN), 20);
    for (int i = 1; i < 3; i++) begin
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== e[i]) begin errors++; $display("FAIL b2b[%0d] got %h exp %h", i, snap, e[i]); end
      step();
    end
    // Exactly STEP normalises; STEP-1 and then zero stay in RUN.
    do_sample(80);
    g[0] = mk(31, 1, 0, 0, int'(ST_NORM), 100);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== g[0]) begin errors++; $display("FAIL edge_step got %h exp %h", snap, g[0]); end
    step();
    g[1] = mk(32, 1, 1, 1, int'(ST_RUN), 0);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== g[1]) begin errors++; $display("FAIL edge_step_done got %h exp %h", snap, g[1]); end
    do_sample(99);
    g[2] = mk(32, 1, 1, 0, int'(ST_RUN), 99);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== g[2]) begin errors++; $display("FAIL edge_below got %h exp %h", snap, g[2]); end
    do_sample(-99);
    g[3] = mk(32, 1, 1, 0, int'(ST_RUN), 0);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== g[3]) begin errors++; $display("FAIL edge_zero got %h exp %h", snap, g[3]); end
  endtask

  task automatic test_rst_mid_norm();
    logic [SNAP_W-1:0] e;
    do_sample(300);
    e = mk(32, 1, 0, 0, int'(ST_NORM), 300);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL pre_rst got %h exp %h", snap, e); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = mk(0, 0, 0, 0, int'(ST_UNINIT), 0);
    for (int i = 0; i < 2; i++) begin
      snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
      checks++;
      if (snap !== e) begin errors++; $display("FAIL rst_mid_norm[%0d] got %h exp %h", i, snap, e); end
      step();
    end
  endtask

  task automatic test_eff();
    logic [SNAP_W-1:0] e;
    do_init(10);
    do_sample(512);
    e = mk(10, 1, 0, 0, int'(ST_RUN), 0);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL eff_stage got %h exp %h", snap, e); end
    step();
    e = mk(10, 1, 0, 0, int'(ST_NORM), 500);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL eff_acc got %h exp %h", snap, e); end
    for (int i = 0; i < 5; i++) step();
    e = mk(15, 1, 1, 1, int'(ST_RUN), 0);
    snap = {soc_percent, soc_valid, sample_ready, soc_update, dbg_state, dbg_residual};
    checks++;
    if (snap !== e) begin errors++; $display("FAIL eff_done got %h exp %h", snap, e); end
  endtask

  initial begin
    test_reset();
`ifdef SOC_COULOMB_EFF_EN
    test_eff();
`else
    test_norm_up();
    test_floor_clamp();
    test_ceiling_clamp();
    test_init_preempt();
    test_back_to_back();
    test_rst_mid_norm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
